// File: rtl/matmul_job_sequencer.sv
// Job queue and launch sequencer in front of the matrix-multiply core: buffers
// job descriptors, launches them one at a time and keeps done/error tallies.
module matmul_job_sequencer #(
   parameter int MAT_SIZE_BITS  = 4,
   parameter int BRAM_DEPTH     = 10,
   parameter int QUEUE_DEPTH    = 4,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_W          = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               job_valid_i,
   output logic                               job_ready_o,
   input  logic [MAT_SIZE_BITS-1:0]           job_m_i,
   input  logic [MAT_SIZE_BITS-1:0]           job_n_i,
   input  logic [MAT_SIZE_BITS-1:0]           job_k_i,
   input  logic [BRAM_DEPTH-1:0]              job_base_in1_i,
   input  logic [BRAM_DEPTH-1:0]              job_base_in2_i,
   input  logic [BRAM_DEPTH-1:0]              job_base_out_i,
   output logic                               core_start_o,
   output logic [MAT_SIZE_BITS-1:0]           core_m_o,
   output logic [MAT_SIZE_BITS-1:0]           core_n_o,
   output logic [MAT_SIZE_BITS-1:0]           core_k_o,
   output logic [BRAM_DEPTH-1:0]              core_base_in1_o,
   output logic [BRAM_DEPTH-1:0]              core_base_in2_o,
   output logic [BRAM_DEPTH-1:0]              core_base_out_o,
   input  logic                               core_done_i,
   input  logic                               core_err_i,
   input  logic                               halt_clr_i,
   output logic                               busy_o,
   output logic                               halted_o,
   output logic [CNT_W-1:0]                   jobs_done_o,
   output logic [CNT_W-1:0]                   jobs_err_o,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   q_level_o
);

   // state | meaning
   // IDLE  | waiting for a queued job
   // LOAD  | pop head into core_* registers, reject zero-dimension jobs
   // FIRE  | one-cycle core_start, arm the watchdog
   // WAIT  | wait for a rising core_done, accumulate core_err
   // HALT  | watchdog expired; no launches until halt_clr_i

   localparam int LVL_W = $clog2(QUEUE_DEPTH + 1);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef struct packed {
      logic [MAT_SIZE_BITS-1:0] m;
      logic [MAT_SIZE_BITS-1:0] n;
      logic [MAT_SIZE_BITS-1:0] k;
      logic [BRAM_DEPTH-1:0]    b1;
      logic [BRAM_DEPTH-1:0]    b2;
      logic [BRAM_DEPTH-1:0]    bo;
   } job_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_FIRE = 3'd2,
      ST_WAIT = 3'd3,
      ST_HALT = 3'd4
   } state_t;

   state_t            state_q, state_d;
   job_t              fifo_q [QUEUE_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]  level_q, level_d;
   job_t              core_q, core_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              err_seen_q, err_seen_d;
   logic              done_q;
   logic [CNT_W-1:0]  jobs_done_q, jobs_done_d;
   logic [CNT_W-1:0]  jobs_err_q, jobs_err_d;
   logic              push, pop, done_edge, done_inc, err_inc;
   job_t              job_in, head;

   assign job_in      = '{m: job_m_i, n: job_n_i, k: job_k_i,
                          b1: job_base_in1_i, b2: job_base_in2_i, bo: job_base_out_i};
   assign head        = fifo_q[rd_ptr_q];
   assign job_ready_o = (level_q < LVL_W'(QUEUE_DEPTH));
   assign push        = job_valid_i & job_ready_o;
   assign pop         = (state_q == ST_LOAD);
   assign done_edge   = core_done_i & ~done_q;

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Storage has no reset: the level register alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= job_in;
   end

   always_comb begin
      state_d    = state_q;
      core_d     = core_q;
      timer_d    = timer_q;
      err_seen_d = err_seen_q;
      done_inc   = 1'b0;
      err_inc    = 1'b0;
      case (state_q)
         ST_IDLE: if (level_q != '0) state_d = ST_LOAD;
         ST_LOAD: begin
            core_d = head;
            if ((head.m == '0) || (head.n == '0) || (head.k == '0)) begin
               err_inc = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_FIRE;
            end
         end
         ST_FIRE: begin
            timer_d    = TMO_LOAD;
            err_seen_d = 1'b0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            err_seen_d = err_seen_q | core_err_i;
            if (done_edge) begin
               done_inc = 1'b1;
               err_inc  = err_seen_q | core_err_i;
               state_d  = ST_IDLE;
            end else if (timer_q == '0) begin
               err_inc = 1'b1;
               state_d = ST_HALT;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         ST_HALT: if (halt_clr_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign jobs_done_d = (done_inc && (jobs_done_q != CNT_MAX)) ? jobs_done_q + CNT_W'(1) : jobs_done_q;
   assign jobs_err_d  = (err_inc && (jobs_err_q != CNT_MAX)) ? jobs_err_q + CNT_W'(1) : jobs_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         core_q      <= '0;
         timer_q     <= '0;
         err_seen_q  <= 1'b0;
         done_q      <= 1'b0;
         jobs_done_q <= '0;
         jobs_err_q  <= '0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         core_q      <= core_d;
         timer_q     <= timer_d;
         err_seen_q  <= err_seen_d;
         done_q      <= core_done_i;
         jobs_done_q <= jobs_done_d;
         jobs_err_q  <= jobs_err_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   assign core_start_o    = (state_q == ST_FIRE);
   assign core_m_o        = core_q.m;
   assign core_n_o        = core_q.n;
   assign core_k_o        = core_q.k;
   assign core_base_in1_o = core_q.b1;
   assign core_base_in2_o = core_q.b2;
   assign core_base_out_o = core_q.bo;
   assign busy_o          = (state_q == ST_LOAD) || (state_q == ST_FIRE) || (state_q == ST_WAIT);
   assign halted_o        = (state_q == ST_HALT);
   assign jobs_done_o     = jobs_done_q;
   assign jobs_err_o      = jobs_err_q;
   assign q_level_o       = level_q;

endmodule
